// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_seq_state_t;

  // Request bit positions; a higher index wins arbitration.
  localparam int unsigned REQ_JMP  = 0;
  localparam int unsigned REQ_CALL = 1;
  localparam int unsigned REQ_RET  = 2;
  localparam int unsigned REQ_IRET = 3;
  localparam int unsigned REQ_IRQ  = 4;
  localparam int unsigned REQ_HALT = 5;
  localparam int unsigned REQ_N    = 6;

  localparam int unsigned PC_SEQ_PC_W      = 8;
  localparam logic [7:0]  PC_SEQ_RESET_VEC = 8'h00;
  localparam logic [7:0]  PC_SEQ_IRQ_VEC   = 8'hF0;

endpackage

// File: rtl/pc_ret_stack.sv
// Circular return-address LIFO: a push when full overwrites the oldest entry,
// a pop when empty leaves the stack untouched. Overflow/underflow flag the current op.
module pc_ret_stack #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] top_o,
  output logic         empty_o,
  output logic         full_o,
  output logic         ovf_o,
  output logic         unf_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]             sp_q;
  logic [AW:0]               cnt_q;
  logic [DEPTH-1:0][W-1:0]   mem_q;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign ovf_o   = push_i & full_o;
  assign unf_o   = pop_i & empty_o;
  assign top_o   = mem_q[sp_q - AW'(1)];

  // sp wraps modulo DEPTH, so a full push lands on the oldest slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else if (push_i) begin
      sp_q <= sp_q + AW'(1);
      if (!full_o) cnt_q <= cnt_q + (AW+1)'(1);
    end else if (pop_i && !empty_o) begin
      sp_q  <= sp_q - AW'(1);
      cnt_q <= cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[sp_q] <= data_i;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Branch/run/halt sequencer driving the P_C register with registered commands.
// Define PC_SEQ_RAS_EN to enable call/return through the return-address stack.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned     PC_W      = PC_SEQ_PC_W,
  parameter logic [PC_W-1:0] RESET_VEC = PC_W'(PC_SEQ_RESET_VEC),
  parameter logic [PC_W-1:0] IRQ_VEC   = PC_W'(PC_SEQ_IRQ_VEC),
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            power,
  input  logic            run_req,
  input  logic            halt_req,
  input  logic            irq_req,
  input  logic            iret_req,
  input  logic            jmp_req,
  input  logic            call_req,
  input  logic            ret_req,
  input  logic [PC_W-1:0] jmp_target,
  input  logic [PC_W-1:0] pc,
  output logic            branch_en,
  output logic [PC_W-1:0] branch_pc,
  output logic            stop_en,
  output logic            ack,
  output logic            in_isr,
  output logic [PC_W-1:0] epc,
  output logic            ras_err
);

`ifdef PC_SEQ_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  pc_seq_state_t   state_q, state_d;
  logic            ben_q, ben_d, stop_q, stop_d, ack_q, ack_d, isr_q, isr_d;
  logic [PC_W-1:0] bpc_q, bpc_d, epc_q, epc_d;
  logic [REQ_N-1:0] elig;
  int unsigned     win;

`ifdef PC_SEQ_RAS_EN
  logic            push, pop, stk_empty, stk_full, stk_ovf, stk_unf, ras_err_q;
  logic [PC_W-1:0] stk_top;

  pc_ret_stack #(.W(PC_W), .DEPTH(RAS_DEPTH)) u_stk (
    .clk     (clk),
    .rst_n   (power),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (pc + PC_W'(1)),
    .top_o   (stk_top),
    .empty_o (stk_empty),
    .full_o  (stk_full),
    .ovf_o   (stk_ovf),
    .unf_o   (stk_unf)
  );

  always_ff @(posedge clk or negedge power) begin
    if (!power) ras_err_q <= 1'b0;
    else        ras_err_q <= ras_err_q | stk_ovf | stk_unf;
  end
  assign ras_err = ras_err_q;
`else
  assign ras_err = 1'b0;
`endif

  // Masked irq / unmatched iret drop out here so the next request is considered.
  always_comb begin
    elig           = '0;
    elig[REQ_HALT] = halt_req;
    elig[REQ_IRQ]  = irq_req & ~isr_q;
    elig[REQ_IRET] = iret_req & isr_q;
    elig[REQ_RET]  = ret_req & RAS_EN;
    elig[REQ_CALL] = call_req;
    elig[REQ_JMP]  = jmp_req;
    win = REQ_JMP;
    for (int unsigned i = 0; i < REQ_N; i++)
      if (elig[i]) win = i;
  end

  always_comb begin
    state_d = state_q;
    ben_d   = 1'b0;
    bpc_d   = bpc_q;
    stop_d  = stop_q;
    ack_d   = 1'b0;
    isr_d   = isr_q;
    epc_d   = epc_q;
`ifdef PC_SEQ_RAS_EN
    push    = 1'b0;
    pop     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        stop_d = 1'b1;
        if (run_req) begin
          state_d = ST_RUN;
          stop_d  = 1'b0;
          ben_d   = 1'b1;
          bpc_d   = RESET_VEC;
          ack_d   = 1'b1;
        end
      end
      ST_RUN: begin
        stop_d = 1'b0;
        if (|elig) begin
          ack_d = 1'b1;
          case (win)
            REQ_HALT: begin
              state_d = ST_HALT;
              stop_d  = 1'b1;
            end
            REQ_IRQ: begin
              epc_d = pc;
              isr_d = 1'b1;
              ben_d = 1'b1;
              bpc_d = IRQ_VEC;
            end
            REQ_IRET: begin
              isr_d = 1'b0;
              ben_d = 1'b1;
              bpc_d = epc_q;
            end
`ifdef PC_SEQ_RAS_EN
            REQ_RET: begin
              pop = 1'b1;
              if (!stk_empty) begin
                ben_d = 1'b1;
                bpc_d = stk_top;
              end
            end
            REQ_CALL: begin
              push  = 1'b1;
              ben_d = 1'b1;
              bpc_d = jmp_target;
            end
`endif
            default: begin
              ben_d = 1'b1;
              bpc_d = jmp_target;
            end
          endcase
        end
      end
      ST_HALT: begin
        stop_d = 1'b1;
        if (run_req) begin
          state_d = ST_RUN;
          stop_d  = 1'b0;
          ack_d   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        stop_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge power) begin
    if (!power) begin
      state_q <= ST_IDLE;
      ben_q   <= 1'b0;
      bpc_q   <= '0;
      stop_q  <= 1'b1;
      ack_q   <= 1'b0;
      isr_q   <= 1'b0;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      ben_q   <= ben_d;
      bpc_q   <= bpc_d;
      stop_q  <= stop_d;
      ack_q   <= ack_d;
      isr_q   <= isr_d;
      epc_q   <= epc_d;
    end
  end

  assign branch_en = ben_q;
  assign branch_pc = bpc_q;
  assign stop_en   = stop_q;
  assign ack       = ack_q;
  assign in_isr    = isr_q;
  assign epc       = epc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer against a queue-based behavioural model;
// follows PC_SEQ_RAS_EN so both builds are checked with the same stimulus.
module tb_pc_sequencer;

`ifdef PC_SEQ_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       power = 1'b0;
  logic       run_req = 0, halt_req = 0, irq_req = 0, iret_req = 0;
  logic       jmp_req = 0, call_req = 0, ret_req = 0;
  logic [7:0] jmp_target = 8'h00, pc = 8'h00;
  logic       branch_en, stop_en, ack, in_isr, ras_err;
  logic [7:0] branch_pc, epc;

  int cmps = 0;
  int fails = 0;

  pc_sequencer #(.PC_W(8), .RESET_VEC(8'h00), .IRQ_VEC(8'hF0), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .power(power), .run_req(run_req), .halt_req(halt_req),
    .irq_req(irq_req), .iret_req(iret_req), .jmp_req(jmp_req), .call_req(call_req),
    .ret_req(ret_req), .jmp_target(jmp_target), .pc(pc), .branch_en(branch_en),
    .branch_pc(branch_pc), .stop_en(stop_en), .ack(ack), .in_isr(in_isr),
    .epc(epc), .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode 0 idle, 1 running, 2 halted.
  int         m_mode;
  logic       m_ben, m_stop, m_ack, m_isr, m_err;
  logic [7:0] m_bpc, m_epc;
  logic [7:0] m_ras[$];

  logic [20:0] obs;
  assign obs = {branch_en, branch_en ? branch_pc : 8'h00, stop_en, ack, in_isr, epc, ras_err};

  function automatic logic [20:0] expv();
    return {m_ben, m_ben ? m_bpc : 8'h00, m_stop, m_ack, m_isr, m_epc, m_err};
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_ben = 0; m_bpc = 0; m_stop = 1; m_ack = 0;
    m_isr = 0; m_epc = 0; m_err = 0;
    m_ras.delete();
  endfunction

  function automatic void model_update();
    m_ben = 0; m_ack = 0;
    if (m_mode == 0) begin
      if (run_req) begin m_mode = 1; m_stop = 0; m_ben = 1; m_bpc = 8'h00; m_ack = 1; end
    end else if (m_mode == 2) begin
      if (run_req) begin m_mode = 1; m_stop = 0; m_ack = 1; end
    end else begin
      m_stop = 0;
      if (halt_req) begin m_mode = 2; m_stop = 1; m_ack = 1; end
      else if (irq_req && !m_isr) begin
        m_epc = pc; m_isr = 1; m_ben = 1; m_bpc = 8'hF0; m_ack = 1;
      end else if (iret_req && m_isr) begin
        m_isr = 0; m_ben = 1; m_bpc = m_epc; m_ack = 1;
      end else if (RAS && ret_req) begin
        m_ack = 1;
        if (m_ras.size() == 0) m_err = 1;
        else begin m_ben = 1; m_bpc = m_ras.pop_back(); end
      end else if (call_req || jmp_req) begin
        m_ack = 1; m_ben = 1; m_bpc = jmp_target;
        if (RAS && call_req && !(jmp_req && 0)) begin
          m_ras.push_back(8'(pc + 8'd1));
          if (m_ras.size() > DEPTH) begin void'(m_ras.pop_front()); m_err = 1; end
        end
      end
    end
  endfunction

  task automatic step();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_reqs();
    run_req = 0; halt_req = 0; irq_req = 0; iret_req = 0;
    jmp_req = 0; call_req = 0; ret_req = 0;
  endtask

  task automatic test_reset();
    power = 0; clear_reqs(); model_reset();
    @(negedge clk); @(negedge clk);
    cmps++;
    if ({branch_en, branch_pc, stop_en, ack, in_isr, epc, ras_err} !== {1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      fails++; $display("FAIL reset_values: got %h", {branch_en, branch_pc, stop_en, ack, in_isr, epc, ras_err});
    end
    power = 1;
    jmp_req = 1; irq_req = 1; jmp_target = 8'h55;
    step();
    cmps++;
    if (obs !== expv()) begin fails++; $display("FAIL idle_ignores: got %h want %h", obs, expv()); end
    clear_reqs();
  endtask

  task automatic test_run_start();
    run_req = 1;
    step();
    cmps++;
    if (obs !== expv() || branch_pc !== 8'h00 || stop_en !== 1'b0) begin
      fails++; $display("FAIL run_start: got %h want %h", obs, expv());
    end
    run_req = 0;
    step();
    cmps++;
    if (obs !== expv() || branch_en !== 1'b0) begin fails++; $display("FAIL run_pulse_one_cycle: got %h want %h", obs, expv()); end
  endtask

  task automatic test_irq_jmp();
    pc = 8'h12; irq_req = 1; jmp_req = 1; jmp_target = 8'h40;
    step();
    cmps++;
    if (obs !== expv() || epc !== 8'h12 || branch_pc !== 8'hF0 || in_isr !== 1'b1) begin
      fails++; $display("FAIL irq_wins: got %h want %h", obs, expv());
    end
    irq_req = 0; pc = 8'hF0;
    step();
    cmps++;
    if (obs !== expv() || branch_pc !== 8'h40) begin fails++; $display("FAIL jmp_after_irq: got %h want %h", obs, expv()); end
    jmp_req = 0; iret_req = 1; pc = 8'h41;
    step();
    cmps++;
    if (obs !== expv() || branch_pc !== 8'h12 || in_isr !== 1'b0) begin
      fails++; $display("FAIL iret_returns: got %h want %h", obs, expv());
    end
    iret_req = 0;
  endtask

  task automatic test_irq_masked();
    irq_req = 1; pc = 8'h21;
    step();
    cmps++;
    if (obs !== expv()) begin fails++; $display("FAIL irq_enter: got %h want %h", obs, expv()); end
    pc = 8'hF0;
    step();
    cmps++;
    if (obs !== expv() || ack !== 1'b0 || branch_en !== 1'b0) begin
      fails++; $display("FAIL irq_masked: got %h want %h", obs, expv());
    end
    iret_req = 1; pc = 8'hF1;
    step();
    cmps++;
    if (obs !== expv() || branch_pc !== 8'h21) begin fails++; $display("FAIL iret_over_masked_irq: got %h want %h", obs, expv()); end
    iret_req = 0; pc = 8'h21;
    step();
    cmps++;
    if (obs !== expv() || in_isr !== 1'b1 || branch_pc !== 8'hF0) begin
      fails++; $display("FAIL irq_after_iret: got %h want %h", obs, expv());
    end
    irq_req = 0; iret_req = 1;
    step();
    iret_req = 0;
  endtask

  task automatic test_halt();
    pc = 8'h30; halt_req = 1;
    step();
    halt_req = 0; irq_req = 1; jmp_req = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      cmps++;
      if (obs !== expv() || stop_en !== 1'b1) begin fails++; $display("FAIL halt_hold[%0d]: got %h want %h", i, obs, expv()); end
    end
    irq_req = 0; jmp_req = 0; run_req = 1;
    step();
    cmps++;
    if (obs !== expv() || stop_en !== 1'b0 || branch_en !== 1'b0) begin
      fails++; $display("FAIL halt_resume: got %h want %h", obs, expv());
    end
    run_req = 0;
  endtask

  task automatic test_ras();
    pc = 8'hFF; call_req = 1; jmp_target = 8'h50;
    step();
    cmps++;
    if (obs !== expv() || branch_pc !== 8'h50) begin fails++; $display("FAIL call_wrap: got %h want %h", obs, expv()); end
    call_req = 0; ret_req = 1; pc = 8'h50;
    step();
    cmps++;
    if (obs !== expv()) begin fails++; $display("FAIL ret_wrap: got %h want %h", obs, expv()); end
    ret_req = 0; call_req = 1;
    for (int i = 0; i < 5; i++) begin
      pc = 8'(8'h10 * (i + 1)); jmp_target = 8'(8'h80 + i);
      step();
      cmps++;
      if (obs !== expv()) begin fails++; $display("FAIL nested_call[%0d]: got %h want %h", i, obs, expv()); end
    end
    call_req = 0; ret_req = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      cmps++;
      if (obs !== expv()) begin fails++; $display("FAIL nested_ret[%0d]: got %h want %h", i, obs, expv()); end
    end
    ret_req = 0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      halt_req   = ($urandom_range(0, 15) == 0);
      run_req    = ($urandom_range(0, 3) == 0);
      irq_req    = ($urandom_range(0, 5) == 0);
      iret_req   = ($urandom_range(0, 5) == 0);
      ret_req    = ($urandom_range(0, 4) == 0);
      call_req   = ($urandom_range(0, 3) == 0);
      jmp_req    = ($urandom_range(0, 3) == 0);
      jmp_target = 8'($urandom);
      pc         = 8'($urandom);
      step();
      cmps++;
      if (obs !== expv()) begin fails++; $display("FAIL random[%0d]: got %h want %h", n, obs, expv()); end
    end
    clear_reqs();
  endtask

  task automatic test_power_abort();
    if (m_mode != 1) begin run_req = 1; step(); run_req = 0; end
    if (m_isr) begin iret_req = 1; step(); iret_req = 0; end
    jmp_req = 1; jmp_target = 8'h77;
    step();
    jmp_req = 0;
    cmps++;
    if (obs !== expv() || branch_en !== 1'b1) begin fails++; $display("FAIL abort_setup: got %h want %h", obs, expv()); end
    #2 power = 0;
    #1;
    model_reset();
    cmps++;
    if (obs !== expv() || branch_en !== 1'b0 || stop_en !== 1'b1) begin
      fails++; $display("FAIL power_abort: got %h want %h", obs, expv());
    end
    @(negedge clk);
    power = 1; jmp_req = 1;
    step();
    cmps++;
    if (obs !== expv() || ack !== 1'b0) begin fails++; $display("FAIL abort_idle: got %h want %h", obs, expv()); end
    jmp_req = 0; run_req = 1;
    step();
    cmps++;
    if (obs !== expv() || branch_pc !== 8'h00) begin fails++; $display("FAIL abort_restart: got %h want %h", obs, expv()); end
    run_req = 0;
  endtask

  initial begin
    test_reset();
    test_run_start();
    test_irq_jmp();
    test_irq_masked();
    test_halt();
    test_ras();
    test_random();
    test_power_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, fails);
    $finish;
  end

endmodule
